// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan select generator feeding a 3-to-8 decoder.
package scan_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // True when some enabled channel lies strictly above sel; false means the next step wraps.
    function automatic logic has_above(input logic [NCH-1:0] mask, input sel_t sel);
        logic [NCH-1:0] upper;
        upper = mask & ~((NCH'(2) << sel) - NCH'(1));
        return |upper;
    endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Finds the next enabled channel strictly above cur, wrapping to the lowest one if none.
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [NCH-1:0] ch_mask,
    input  sel_t           cur,
    output sel_t           nxt,
    output logic           wrap,
    output logic           any
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        logic found;
        nxt   = '0;
        wrap  = 1'b1;
        any   = |ch_mask;
        found = 1'b0;
        // Offsets 1..NCH walk the mask rotated to start just above cur; first hit wins.
        for (int k = 1; k <= NCH; k++) begin
            sel_t idx;
            idx = cur + k[SEL_W-1:0];
            if (!found && ch_mask[idx]) begin
                found = 1'b1;
                nxt   = idx;
                wrap  = (idx <= cur);
            end
        end
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Sequential channel select generator: masked ascending scan with programmable dwell.
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DW_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            oneshot,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [DW_W-1:0] dwell,
    output logic            i2,
    output logic            i1,
    output logic            i0,
    output logic            sel_valid,
    output logic            frame_done,
    output logic            busy
);

    state_t          state;
    sel_t            sel_q;
    logic [DW_W-1:0] cnt;
    logic            os_lat;

    sel_t            nxt_sel;
    logic            nxt_wrap;
    logic            nxt_any;
    sel_t            first_sel;
    logic            first_wrap_unused;
    logic            first_any;
    logic [DW_W-1:0] dw_load;

    scan_next_ch u_next (
        .ch_mask (ch_mask),
        .cur     (sel_q),
        .nxt     (nxt_sel),
        .wrap    (nxt_wrap),
        .any     (nxt_any)
    );

    // Searching above channel 7 always wraps, which yields the lowest enabled channel.
    scan_next_ch u_first (
        .ch_mask (ch_mask),
        .cur     (sel_t'(NCH - 1)),
        .nxt     (first_sel),
        .wrap    (first_wrap_unused),
        .any     (first_any)
    );

    assign dw_load     = (dwell == '0) ? '0 : dwell - DW_W'(1);
    assign {i2, i1, i0} = sel_q;

    // frame_done is registered, so it is set on the edge that enters the final dwell cycle.
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= '0;
            cnt        <= '0;
            os_lat     <= 1'b0;
            sel_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && first_any) begin
                        state      <= SCAN;
                        sel_q      <= first_sel;
                        cnt        <= dw_load;
                        os_lat     <= oneshot;
                        sel_valid  <= 1'b1;
                        busy       <= 1'b1;
                        frame_done <= (dw_load == '0) && !has_above(ch_mask, first_sel);
                    end
                end
                SCAN: begin
                    if (!en || (cnt == '0 && (!nxt_any || (nxt_wrap && os_lat)))) begin
                        state     <= IDLE;
                        sel_q     <= '0;
                        cnt       <= '0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt        <= cnt - DW_W'(1);
                        frame_done <= (cnt == DW_W'(1)) && !has_above(ch_mask, sel_q);
                    end else begin
                        sel_q      <= nxt_sel;
                        cnt        <= dw_load;
                        frame_done <= (dw_load == '0) && !has_above(ch_mask, nxt_sel);
                        if (nxt_wrap) begin
                            os_lat <= oneshot;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed self-checking bench for scan_sel_gen with hand-computed expected vectors.
module tb_scan_sel_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       oneshot;
    logic [7:0] ch_mask;
    logic [7:0] dwell;
    logic       i2, i1, i0, sel_valid, frame_done, busy;

    int checks = 0;
    int errors = 0;

    scan_sel_gen #(.DW_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .oneshot    (oneshot),
        .ch_mask    (ch_mask),
        .dwell      (dwell),
        .i2         (i2),
        .i1         (i1),
        .i0         (i0),
        .sel_valid  (sel_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Packed view {select[2:0], sel_valid, busy, frame_done}.
    function automatic logic [5:0] obs();
        return {i2, i1, i0, sel_valid, busy, frame_done};
    endfunction

    function automatic logic [5:0] exp_vec(input int sel, input logic v, input logic b, input logic fd);
        logic [2:0] s;
        s = sel[2:0];
        return {s, v, b, fd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        en = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; oneshot = 1'b0; ch_mask = 8'h00; dwell = 8'd1;
        #1;
        checks++;
        if (obs() !== 6'b000000) begin
            errors++;
            $display("FAIL reset_initial got %b want %b", obs(), 6'b000000);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_scan();
        ch_mask = 8'hFF; dwell = 8'd2; oneshot = 1'b0; en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step();
            checks++;
            if (obs() !== exp_vec((i / 2) % 8, 1'b1, 1'b1, (i % 16) == 15)) begin
                errors++;
                $display("FAIL full_scan[%0d] got %b want %b", i, obs(),
                         exp_vec((i / 2) % 8, 1'b1, 1'b1, (i % 16) == 15));
            end
        end
        en = 1'b0;
        step();
        checks++;
        if (obs() !== 6'b000000) begin
            errors++;
            $display("FAIL full_scan_stop got %b want %b", obs(), 6'b000000);
        end
        go_idle();
    endtask

    task automatic test_oneshot_masked();
        logic [5:0] exp_t [4];
        exp_t[0] = exp_vec(2, 1'b1, 1'b1, 1'b0);
        exp_t[1] = exp_vec(4, 1'b1, 1'b1, 1'b0);
        exp_t[2] = exp_vec(7, 1'b1, 1'b1, 1'b1);
        exp_t[3] = exp_vec(0, 1'b0, 1'b0, 1'b0);
        ch_mask = 8'h94; dwell = 8'd1; oneshot = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs() !== exp_t[i]) begin
                errors++;
                $display("FAIL oneshot_masked[%0d] got %b want %b", i, obs(), exp_t[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_single_dwell0();
        ch_mask = 8'h08; dwell = 8'd0; oneshot = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs() !== exp_vec(3, 1'b1, 1'b1, 1'b1)) begin
                errors++;
                $display("FAIL single_dwell0[%0d] got %b want %b", i, obs(), exp_vec(3, 1'b1, 1'b1, 1'b1));
            end
        end
        go_idle();
    endtask

    task automatic test_disable_mid();
        ch_mask = 8'hFF; dwell = 8'd3; oneshot = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs() !== exp_vec(i / 3, 1'b1, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL disable_run[%0d] got %b want %b", i, obs(), exp_vec(i / 3, 1'b1, 1'b1, 1'b0));
            end
        end
        en = 1'b0;
        step();
        checks++;
        if (obs() !== 6'b000000) begin
            errors++;
            $display("FAIL disable_idle got %b want %b", obs(), 6'b000000);
        end
        go_idle();
    endtask

    task automatic test_mask_change();
        int exp_sel [5] = '{4, 4, 4, 4, 6};
        ch_mask = 8'h70; dwell = 8'd4; oneshot = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs() !== exp_vec(exp_sel[i], 1'b1, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL mask_change[%0d] got %b want %b", i, obs(), exp_vec(exp_sel[i], 1'b1, 1'b1, 1'b0));
            end
            if (i == 1) ch_mask = 8'h50;
        end
        go_idle();
    endtask

    task automatic test_empty_mask();
        ch_mask = 8'h00; dwell = 8'd2; oneshot = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs() !== 6'b000000) begin
                errors++;
                $display("FAIL empty_mask[%0d] got %b want %b", i, obs(), 6'b000000);
            end
        end
        ch_mask = 8'h01;
        step();
        checks++;
        if (obs() !== exp_vec(0, 1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL empty_then_set got %b want %b", obs(), exp_vec(0, 1'b1, 1'b1, 1'b0));
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        ch_mask = 8'hFF; dwell = 8'd1; oneshot = 1'b0; en = 1'b1;
        for (int i = 0; i < 16 && !reached; i++) begin
            step();
            if ({i2, i1, i0} == 3'b101) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL reset_mid_reach got %b want select 101", {i2, i1, i0});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 6'b000000) begin
            errors++;
            $display("FAIL reset_mid_async got %b want %b", obs(), 6'b000000);
        end
        en = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs() !== 6'b000000) begin
                errors++;
                $display("FAIL reset_mid_idle[%0d] got %b want %b", i, obs(), 6'b000000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_oneshot_masked();
        test_single_dwell0();
        test_disable_mid();
        test_mask_change();
        test_empty_mask();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
